// File: rtl/td4_program_sequencer_if.sv
// td4_program_sequencer_if: host command/load port and CPU control bus of the program sequencer; SEQ_BREAKPOINT_EN adds bp_enable/bp_addr/bp_hit
interface td4_program_sequencer_if #(parameter int PRESCALE_W = 8);
  logic                  cmd_load;
  logic                  cmd_run;
  logic                  cmd_step;
  logic                  cmd_stop;
  logic [PRESCALE_W-1:0] prescale;
  logic                  wr_valid;
  logic [7:0]            wr_data;
  logic                  wr_ready;
  logic                  load_done;
  logic [3:0]            cpu_pc;
  logic [3:0]            cpu_opcode;
  logic [3:0]            cpu_imm;
  logic                  cpu_exec;
  logic                  cpu_rst_n;
  logic                  step_done;
  logic                  halted;
  logic [2:0]            state;
`ifdef SEQ_BREAKPOINT_EN
  logic                  bp_enable;
  logic [3:0]            bp_addr;
  logic                  bp_hit;
  modport master (
    output cmd_load, cmd_run, cmd_step, cmd_stop, prescale, wr_valid, wr_data, cpu_pc, bp_enable, bp_addr,
    input  wr_ready, load_done, cpu_opcode, cpu_imm, cpu_exec, cpu_rst_n, step_done, halted, state, bp_hit
  );
  modport slave (
    input  cmd_load, cmd_run, cmd_step, cmd_stop, prescale, wr_valid, wr_data, cpu_pc, bp_enable, bp_addr,
    output wr_ready, load_done, cpu_opcode, cpu_imm, cpu_exec, cpu_rst_n, step_done, halted, state, bp_hit
  );
`else
  modport master (
    output cmd_load, cmd_run, cmd_step, cmd_stop, prescale, wr_valid, wr_data, cpu_pc,
    input  wr_ready, load_done, cpu_opcode, cpu_imm, cpu_exec, cpu_rst_n, step_done, halted, state
  );
  modport slave (
    input  cmd_load, cmd_run, cmd_step, cmd_stop, prescale, wr_valid, wr_data, cpu_pc,
    output wr_ready, load_done, cpu_opcode, cpu_imm, cpu_exec, cpu_rst_n, step_done, halted, state
  );
`endif
endinterface

// File: rtl/td4_program_sequencer.sv
// td4_program_sequencer: 16x8 program store plus load/run/step sequencer for a TD4-style core; SEQ_BREAKPOINT_EN adds a run-mode PC breakpoint
module td4_program_sequencer #(
  parameter int PRESCALE_W = 8
) (
  input logic clk,
  input logic rst,
  td4_program_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FETCH = 3'd2,
    EXEC  = 3'd3,
    WAIT  = 3'd4,
    HALT  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic                  run_q, run_d;
  logic [3:0]            waddr_q, waddr_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [3:0]            opc_q, imm_q;
  logic                  load_done_q, load_done_d;
  logic                  step_done_q, step_done_d;
  logic                  rst_q;
  logic                  we;
  logic                  fetch;
  logic [7:0]            mem [16];
  logic [7:0]            rd;
`ifdef SEQ_BREAKPOINT_EN
  logic                  bp_q, bp_d;
`endif

  assign rd = mem[bus.cpu_pc];

  // next-state and pulse decode; a jump-to-self fetch is the halt condition
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    waddr_d     = waddr_q;
    cnt_d       = cnt_q;
    we          = 1'b0;
    fetch       = 1'b0;
    load_done_d = 1'b0;
    step_done_d = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
    bp_d        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!bus.cmd_stop) begin
          if (bus.cmd_load) begin
            state_d = LOAD;
            waddr_d = 4'd0;
          end else if (bus.cmd_run || bus.cmd_step) begin
            state_d = FETCH;
            run_d   = bus.cmd_run;
          end
        end
      end
      LOAD: begin
        we      = bus.wr_valid;
        waddr_d = waddr_q + 4'(we);
        if (bus.cmd_stop) state_d = IDLE;
        else if (we && waddr_q == 4'd15) begin
          state_d     = IDLE;
          load_done_d = 1'b1;
        end
      end
      FETCH: begin
        fetch   = 1'b1;
        state_d = (rd[7:4] == 4'hF && rd[3:0] == bus.cpu_pc) ? HALT : EXEC;
`ifdef SEQ_BREAKPOINT_EN
        if (run_q && bus.bp_enable && bus.cpu_pc == bus.bp_addr) begin
          state_d = IDLE;
          bp_d    = !bus.cmd_stop;
        end
`endif
        if (bus.cmd_stop) state_d = IDLE;
      end
      EXEC: begin
        state_d     = (run_q && !bus.cmd_stop) ? WAIT : IDLE;
        cnt_d       = bus.prescale;
        step_done_d = !run_q;
      end
      WAIT: begin
        state_d = bus.cmd_stop ? IDLE : (cnt_q == '0 ? FETCH : WAIT);
        cnt_d   = cnt_q - 1'b1;
      end
      HALT: begin
        if (bus.cmd_stop) state_d = IDLE;
        else if (bus.cmd_load) begin
          state_d = LOAD;
          waddr_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // control registers; rst_q keeps the CPU in reset for the cycle after rst
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      waddr_q     <= 4'd0;
      cnt_q       <= '0;
      opc_q       <= 4'd0;
      imm_q       <= 4'd0;
      load_done_q <= 1'b0;
      step_done_q <= 1'b0;
      rst_q       <= 1'b1;
`ifdef SEQ_BREAKPOINT_EN
      bp_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      waddr_q     <= waddr_d;
      cnt_q       <= cnt_d;
      load_done_q <= load_done_d;
      step_done_q <= step_done_d;
      rst_q       <= 1'b0;
      if (fetch) {opc_q, imm_q} <= rd;
`ifdef SEQ_BREAKPOINT_EN
      bp_q        <= bp_d;
`endif
    end
  end

  // program store survives reset; a write coinciding with rst is dropped
  always_ff @(posedge clk) begin
    if (!rst && we) mem[waddr_q] <= bus.wr_data;
  end

  assign bus.wr_ready   = state_q == LOAD;
  assign bus.load_done  = load_done_q;
  assign bus.cpu_opcode = opc_q;
  assign bus.cpu_imm    = imm_q;
  assign bus.cpu_exec   = state_q == EXEC;
  assign bus.cpu_rst_n  = !rst_q && state_q != LOAD;
  assign bus.step_done  = step_done_q;
  assign bus.halted     = state_q == HALT;
  assign bus.state      = state_q;
`ifdef SEQ_BREAKPOINT_EN
  assign bus.bp_hit     = bp_q;
`endif
endmodule

// File: tb/tb_td4_program_sequencer.sv
// tb_td4_program_sequencer: scoreboard bench with a tiny TD4 core model driving cpu_pc
module tb_td4_program_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  td4_program_sequencer_if #(.PRESCALE_W(8)) sif ();
  td4_program_sequencer #(.PRESCALE_W(8)) dut (.clk(clk), .rst(rst), .bus(sif));

  int n_chk = 0;
  int n_fail = 0;
  int n_exec = 0;
  int n_ld = 0;
  int n_sd = 0;
  int cyc = 0;
  int exec_t[$];
  logic [7:0] exp_q[$];
  logic [7:0] prog [16];
  logic [3:0] m_pc = 4'd0;
  logic [3:0] m_a = 4'd0;
  logic [3:0] m_out = 4'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [3:0] c);
    {sif.cmd_stop, sif.cmd_load, sif.cmd_run, sif.cmd_step} = c;
    tick();
    {sif.cmd_stop, sif.cmd_load, sif.cmd_run, sif.cmd_step} = 4'b0000;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // minimal core: 0=ADD A,imm  C=MOV A,imm  D=OUT imm  F=JMP imm  others advance pc
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!sif.cpu_rst_n) begin
      m_pc  <= 4'd0;
      m_a   <= 4'd0;
      m_out <= 4'd0;
    end else if (sif.cpu_exec) begin
      m_pc <= (sif.cpu_opcode == 4'hF) ? sif.cpu_imm : m_pc + 4'd1;
      if (sif.cpu_opcode == 4'h0) m_a <= m_a + sif.cpu_imm;
      if (sif.cpu_opcode == 4'hC) m_a <= sif.cpu_imm;
      if (sif.cpu_opcode == 4'hD) m_out <= sif.cpu_imm;
    end
  end
  assign sif.cpu_pc = m_pc;

  // scoreboard: every exec strobe must match the next queued instruction byte
  always @(negedge clk) begin
    if (sif.cpu_exec) begin
      n_exec++;
      exec_t.push_back(cyc);
      if (exp_q.size() == 0) chk("exec_unexpected", 32'(1), 32'(0));
      else chk("exec_byte", 32'({sif.cpu_opcode, sif.cpu_imm}), 32'(exp_q.pop_front()));
    end
    if (sif.load_done) n_ld++;
    if (sif.step_done) n_sd++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1);
  end

  initial begin
    int e0;
    int t0;
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = 8'hC5;
    prog[1] = 8'h03;
    prog[2] = 8'hD7;
    prog[3] = 8'hF3;
    {sif.cmd_stop, sif.cmd_load, sif.cmd_run, sif.cmd_step} = 4'b0000;
    sif.prescale = 8'd0;
    sif.wr_valid = 1'b0;
    sif.wr_data  = 8'h00;
`ifdef SEQ_BREAKPOINT_EN
    sif.bp_enable = 1'b0;
    sif.bp_addr   = 4'd0;
`endif
    repeat (3) tick();
    chk("rst_state", 32'(sif.state), 32'(0));
    chk("rst_outs", 32'({sif.wr_ready, sif.load_done, sif.cpu_exec, sif.step_done, sif.halted}), 32'(0));
    chk("rst_cpu_rst_n", 32'(sif.cpu_rst_n), 32'(0));
    chk("rst_op_imm", 32'({sif.cpu_opcode, sif.cpu_imm}), 32'(0));
    rst = 1'b0;
    tick();
    chk("rel_cpu_rst_n", 32'(sif.cpu_rst_n), 32'(1));

    cmd(4'b0100);
    chk("load_state", 32'(sif.state), 32'(1));
    for (int i = 0; i < 16; i++) begin
      chk("load_hs", 32'({sif.wr_ready, sif.cpu_rst_n}), 32'(2'b10));
      sif.wr_valid = 1'b1;
      sif.wr_data  = prog[i];
      tick();
      sif.wr_valid = 1'b0;
      tick();
    end
    chk("load_end_state", 32'(sif.state), 32'(0));
    chk("load_done_cnt", 32'(n_ld), 32'(1));

    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(prog[k]);
      cmd(4'b0001);
      repeat (4) tick();
    end
    chk("step_execs", 32'(n_exec), 32'(3));
    chk("step_done_cnt", 32'(n_sd), 32'(3));
    chk("cpu_a", 32'(m_a), 32'(8));
    chk("cpu_out", 32'(m_out), 32'(7));

    rst_pulse();
    chk("pc_reset", 32'(m_pc), 32'(0));
    e0 = n_exec;
    t0 = exec_t.size();
    exp_q.push_back(8'hC5);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'hD7);
    sif.prescale = 8'd0;
    cmd(4'b0010);
    for (int i = 0; i < 30 && !sif.halted; i++) tick();
    chk("run_halted", 32'(sif.halted), 32'(1));
    chk("run_execs", 32'(n_exec - e0), 32'(3));
    chk("run_period_a", 32'(exec_t[t0+1] - exec_t[t0]), 32'(3));
    chk("run_period_b", 32'(exec_t[t0+2] - exec_t[t0+1]), 32'(3));
    repeat (4) tick();
    chk("halt_no_exec", 32'(n_exec - e0), 32'(3));
    cmd(4'b0010);
    chk("halt_run_ignored", 32'(sif.state), 32'(5));
    cmd(4'b1000);
    chk("halt_stop", 32'(sif.state), 32'(0));

    rst_pulse();
    e0 = n_exec;
    t0 = exec_t.size();
    exp_q.push_back(8'hC5);
    exp_q.push_back(8'h03);
    sif.prescale = 8'd5;
    cmd(4'b0010);
    for (int i = 0; i < 60 && (n_exec - e0) < 2; i++) tick();
    repeat (2) tick();
    chk("ps5_in_wait", 32'(sif.state), 32'(4));
    cmd(4'b1000);
    chk("ps5_stop_wait", 32'(sif.state), 32'(0));
    repeat (20) tick();
    chk("ps5_execs", 32'(n_exec - e0), 32'(2));
    chk("ps5_period", 32'(exec_t[t0+1] - exec_t[t0]), 32'(8));

    rst_pulse();
    e0 = n_exec;
    exp_q.push_back(8'hC5);
    cmd(4'b0010);
    for (int i = 0; i < 10 && sif.state != 3'd3; i++) tick();
    chk("reach_exec", 32'(sif.state), 32'(3));
    cmd(4'b1000);
    chk("stop_exec_state", 32'(sif.state), 32'(0));
    repeat (20) tick();
    chk("stop_exec_execs", 32'(n_exec - e0), 32'(1));
    chk("run_no_step_done", 32'(n_sd), 32'(3));

    cmd(4'b0110);
    chk("load_over_run", 32'(sif.state), 32'(1));
    for (int i = 0; i < 4; i++) begin
      sif.wr_valid = 1'b1;
      sif.wr_data  = 8'(8'h31 + 8'(i * 8'h11));
      tick();
    end
    sif.wr_data = 8'h75;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sif.wr_valid = 1'b0;
    chk("rst_mid_load", 32'(sif.state), 32'(0));
    tick();
    e0 = n_exec;
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h53);
    exp_q.push_back(8'h64);
    exp_q.push_back(prog[4]);
    for (int k = 0; k < 5; k++) begin
      cmd(4'b0001);
      repeat (4) tick();
    end
    chk("retained_execs", 32'(n_exec - e0), 32'(5));
    chk("aborted_no_done", 32'(n_ld), 32'(1));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/td4_program_sequencer.md
Name: td4_program_sequencer

Overview:
Controller that owns the 16-entry program store for the 4-bit TD4-style CPU core and sequences its execution. A host loads 16 instruction bytes through a valid/ready write port. The block then fetches `{opcode, immediate}` at the CPU's `pc` and issues one-cycle `exec` strobes, either free-running at a programmable rate or single-stepping. It sits between the host/test interface and the CPU core, driving the core's `opcode`, `immediate`, `exec_mode` and `rst_n` inputs.

Parameters:
PRESCALE_W, 8, width of the run-mode inter-instruction delay counter.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
cmd_load  input  1  pulse: enter LOAD
cmd_run  input  1  pulse: start free-run
cmd_step  input  1  pulse: execute one instruction
cmd_stop  input  1  pulse: abort to IDLE
prescale  input  PRESCALE_W  extra WAIT cycles between instructions in run mode
wr_valid  input  1  host write valid
wr_data  input  8  instruction byte `{opcode[7:4], immediate[3:0]}`
wr_ready  output  1  high only in LOAD
load_done  output  1  one-cycle pulse after the 16th byte is accepted
cpu_pc  input  4  CPU program counter
cpu_opcode  output  4  to CPU opcode
cpu_imm  output  4  to CPU immediate
cpu_exec  output  1  to CPU exec_mode; one-cycle strobe
cpu_rst_n  output  1  to CPU rst_n; low holds the CPU in reset
step_done  output  1  one-cycle pulse when a step completes
halted  output  1  high in HALT
state  output  3  encoded state: IDLE=0, LOAD=1, FETCH=2, EXEC=3, WAIT=4, HALT=5

Behaviour:
- Memory: 16x8, written only in LOAD. It is not cleared by `rst`, so its contents persist across reset and stop.
- Reset (`rst`=1 at a clk edge):
  - state is IDLE and the run_mode flag is 0.
  - Outputs `wr_ready`, `load_done`, `cpu_exec`, `step_done` and `halted` are 0.
  - `cpu_opcode` and `cpu_imm` are 0.
  - `cpu_rst_n` is 0.
- Reset mid-operation: same result from any state; an in-flight write is dropped.
- Outputs `cpu_rst_n`, `wr_ready`, `cpu_exec` and `halted` are Moore outputs decoded from the state register:
  - `cpu_rst_n` is 0 while `rst` is applied and in LOAD; 1 in every other state, from the first clk edge after `rst` is deasserted.
  - `wr_ready` is 1 only in LOAD.
  - `cpu_exec` is 1 only in EXEC.
  - `halted` is 1 only in HALT.
- Command priority when several are high in the same cycle: stop > load > run > step.
- IDLE:
  - `cmd_load` → LOAD; the write address is cleared to 0.
  - `cmd_run` → FETCH with run_mode=1.
  - `cmd_step` → FETCH with run_mode=0.
- LOAD:
  - Each cycle with `wr_valid`=1 writes `mem[waddr]` and increments `waddr`.
  - The write at `waddr`=15 → IDLE, with `load_done` pulsed on the following cycle.
  - `cmd_stop` → IDLE with the partial contents kept and no `load_done`.
  - `cmd_run` and `cmd_step` are ignored.
- FETCH (1 cycle):
  - Registers `cpu_opcode`/`cpu_imm` from `mem[cpu_pc]`.
  - If the fetched byte is `opcode`=1111 with `imm`==`cpu_pc` (jump-to-self) → HALT, and no exec is issued.
  - Otherwise → EXEC.
  - `cmd_stop` → IDLE, no exec.
- EXEC (1 cycle):
  - `cpu_exec`=1.
  - run_mode=1 → WAIT, loading the counter with `prescale`.
  - run_mode=0 → IDLE, with `step_done` pulsed in the next cycle.
  - `cmd_stop` sampled in EXEC: the strobe still completes, then → IDLE.
- WAIT:
  - Counter==0 → FETCH; otherwise decrement.
  - WAIT lasts `prescale`+1 cycles, so the instruction period is `prescale`+3 cycles.
  - `cmd_stop` → IDLE.
  - `cpu_pc` is stable (post-EXEC) throughout WAIT and FETCH.
- HALT:
  - Only `cmd_stop` (→ IDLE) or `cmd_load` (→ LOAD, which resets the CPU) are honoured; run and step are ignored.
  - A run started from IDLE after a HALT halts again immediately, because the CPU's `pc` is unchanged.
- `cpu_opcode`/`cpu_imm` hold their last fetched value outside FETCH.

Optional Feature:
SEQ_BREAKPOINT_EN.
- Defined: adds inputs `bp_enable` (1 bit) and `bp_addr` (4 bits), and output `bp_hit` (1 bit).
  - In FETCH with run_mode=1, `bp_enable`=1 and `cpu_pc`==`bp_addr` → IDLE without exec, and `bp_hit` pulses for one cycle.
  - A subsequent `cmd_step` executes the breakpointed instruction; breakpoints never apply in step mode.
- Undefined: these ports and the logic are absent; behaviour is otherwise identical.

Test Plan:
- `rst` → state=0, `cpu_rst_n`=0 during reset and 1 one cycle after release; `cpu_exec`=0, `wr_ready`=0.
- `cmd_load`, then 16 bytes `{C5,03,D7,F3,00…}` with `wr_valid` gapped every other cycle → `wr_ready`=1 and `cpu_rst_n`=0 throughout; `load_done` pulses once; state=0.
- After load, `cmd_step` ×3 → each gives exactly one `cpu_exec` pulse, with `opcode`/`imm` = C/5, 0/3, D/7; `step_done` ×3; CPU A=8, Out=7.
- `cmd_run` with `prescale`=0 from `pc`=0:
  - `cpu_exec` pulses exactly every 3 cycles, three times;
  - then the fetch of F3 at `pc`=3 → `halted`=1 with no fourth exec;
  - `cmd_run` is ignored; `cmd_stop` → state=0.
- `cmd_run` with `prescale`=5 → exec period 8 cycles; `cmd_stop` asserted in WAIT → IDLE with no further exec; `cmd_stop` asserted in EXEC → that exec still occurs, then IDLE.
- `cmd_load` and `cmd_run` in the same cycle → LOAD; `rst` asserted mid-LOAD after 4 bytes → IDLE, with bytes 0–3 retained (verified by step fetch).
